// File: rtl/approx_mul_sweep_monitor.sv
// Exhaustive signed-operand sweep driving an external multiplier,
// with in-hardware error statistics against the exact product.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start/abort/hold  sweep control
//   op_a/op_b/op_valid operand pair issued to the multiplier
//   dut_r             multiplier result, DUT_LAT cycles after its pair
//   busy/done         RUN or DRAIN / DONE
//   sample_cnt, err_cnt, sum_abs_err, bias_sum,
//   max_abs_err, max_a, max_b   accumulated statistics
module approx_mul_sweep_monitor #(
  parameter int W       = 8,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 2*W+1,
  parameter int ACC_W   = 4*W+2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    hold,
  output logic signed [W-1:0]     op_a,
  output logic signed [W-1:0]     op_b,
  output logic                    op_valid,
  input  logic signed [2*W-1:0]   dut_r,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [ACC_W-1:0]        sum_abs_err,
  output logic signed [ACC_W-1:0] bias_sum,
  output logic [2*W:0]            max_abs_err,
  output logic signed [W-1:0]     max_a,
  output logic signed [W-1:0]     max_b
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  localparam int DW =
    (DUT_LAT > 1) ? $clog2(DUT_LAT+1) : 1;

  localparam logic [W-1:0] MIN_V =
    {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_V =
    {1'b0, {(W-1){1'b1}}};

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          clr;
  logic          last_pair;

  assign clr = start &&
    (state == IDLE || state == DONE);
  assign busy = (state == RUN) ||
    (state == DRAIN);
  assign done = (state == DONE);
  assign op_valid = (state == RUN) && !hold;
  assign last_pair = (op_a == MAX_V) &&
    (op_b == MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            op_a  <= MIN_V;
            op_b  <= MIN_V;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!hold) begin
            if (last_pair) begin
              state <= (DUT_LAT > 0) ?
                DRAIN : DONE;
              drain_cnt <= '0;
            end else if (op_b == MAX_V) begin
              op_b <= MIN_V;
              op_a <= op_a + 1'b1;
            end else begin
              op_b <= op_b + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (drain_cnt ==
                       DW'(DUT_LAT-1)) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pair aligned with dut_r
  logic signed [W-1:0] al_a;
  logic signed [W-1:0] al_b;
  logic                al_v;

  if (DUT_LAT == 0) begin : g_wire
    assign al_a = op_a;
    assign al_b = op_b;
    assign al_v = op_valid;
  end else begin : g_pipe
    logic [W-1:0]       da [DUT_LAT];
    logic [W-1:0]       db [DUT_LAT];
    logic [DUT_LAT-1:0] dv;

    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        dv <= '0;
        for (int i = 0; i < DUT_LAT; i++) begin
          da[i] <= '0;
          db[i] <= '0;
        end
      end else begin
        da[0] <= op_a;
        db[0] <= op_b;
        dv[0] <= op_valid;
        for (int i = 1; i < DUT_LAT; i++) begin
          da[i] <= da[i-1];
          db[i] <= db[i-1];
          dv[i] <= dv[i-1];
        end
      end
    end

    assign al_a = da[DUT_LAT-1];
    assign al_b = db[DUT_LAT-1];
    assign al_v = dv[DUT_LAT-1];
  end

  logic signed [2*W-1:0] a_x;
  logic signed [2*W-1:0] b_x;
  logic signed [2*W-1:0] exact;
  logic signed [2*W:0]   d;
  logic [2*W:0]          abs_d;
  logic                  acc_en;
  logic [ACC_W:0]        sum_nx;
  logic signed [ACC_W:0] bias_nx;

  assign a_x = {{W{al_a[W-1]}}, al_a};
  assign b_x = {{W{al_b[W-1]}}, al_b};
  assign exact = a_x * b_x;
  assign d = {dut_r[2*W-1], dut_r} -
    {exact[2*W-1], exact};
  assign abs_d = d[2*W] ? -d : d;
  // Aligned pairs left in the pipe
  // after an abort are dropped.
  assign acc_en = al_v && busy;

  assign sum_nx = {1'b0, sum_abs_err} +
    {{(ACC_W-2*W){1'b0}}, abs_d};
  assign bias_nx =
    {bias_sum[ACC_W-1], bias_sum} +
    {{(ACC_W-2*W){d[2*W]}}, d};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
      bias_sum    <= '0;
      max_abs_err <= '0;
      max_a       <= '0;
      max_b       <= '0;
    end else if (acc_en) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (d != '0)
        err_cnt <= err_cnt + 1'b1;
      if (sum_nx[ACC_W])
        sum_abs_err <= '1;
      else
        sum_abs_err <= sum_nx[ACC_W-1:0];
      // Top two bits differ: signed overflow
      if (bias_nx[ACC_W] != bias_nx[ACC_W-1])
        bias_sum <= bias_nx[ACC_W] ?
          {1'b1, {(ACC_W-1){1'b0}}} :
          {1'b0, {(ACC_W-1){1'b1}}};
      else
        bias_sum <= bias_nx[ACC_W-1:0];
      if (abs_d > max_abs_err) begin
        max_abs_err <= abs_d;
        max_a       <= al_a;
        max_b       <= al_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_sweep_monitor.sv
// Directed bench for approx_mul_sweep_monitor:
// four instances with different widths, latencies and models.
module tb_approx_mul_sweep_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v;
  logic [3:0] start_v;
  logic [3:0] hold_v;
  logic [3:0] abort_v;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic signed [7:0] mul4(
    input logic signed [3:0] a,
    input logic signed [3:0] b);
    return 8'(int'(a) * int'(b));
  endfunction

  function automatic logic signed [15:0] mul8(
    input logic signed [7:0] a,
    input logic signed [7:0] b);
    return 16'(int'(a) * int'(b));
  endfunction

  // u0: W=4, LAT=2, ideal
  logic signed [3:0]  a0, b0, ma0, mb0;
  logic signed [7:0]  r0, p0a, p0b;
  logic               ov0, bz0, dn0;
  logic [8:0]         sc0, ec0, mx0;
  logic [17:0]        sa0;
  logic signed [17:0] bs0;

  always_ff @(posedge clk) begin
    p0a <= mul4(a0, b0);
    p0b <= p0a;
  end
  assign r0 = p0b;

  approx_mul_sweep_monitor #(.W(4), .DUT_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_v[0]),
    .start(start_v[0]), .abort(abort_v[0]),
    .hold(hold_v[0]),
    .op_a(a0), .op_b(b0), .op_valid(ov0),
    .dut_r(r0), .busy(bz0), .done(dn0),
    .sample_cnt(sc0), .err_cnt(ec0),
    .sum_abs_err(sa0), .bias_sum(bs0),
    .max_abs_err(mx0), .max_a(ma0), .max_b(mb0));

  // u1: W=4, LAT=0, exact+1
  logic signed [3:0]  a1, b1, ma1, mb1;
  logic signed [7:0]  r1;
  logic               ov1, bz1, dn1;
  logic [8:0]         sc1, ec1, mx1;
  logic [17:0]        sa1;
  logic signed [17:0] bs1;

  assign r1 = mul4(a1, b1) + 8'sd1;

  approx_mul_sweep_monitor #(.W(4), .DUT_LAT(0)) u1 (
    .clk(clk), .rst_n(rst_v[1]),
    .start(start_v[1]), .abort(abort_v[1]),
    .hold(hold_v[1]),
    .op_a(a1), .op_b(b1), .op_valid(ov1),
    .dut_r(r1), .busy(bz1), .done(dn1),
    .sample_cnt(sc1), .err_cnt(ec1),
    .sum_abs_err(sa1), .bias_sum(bs1),
    .max_abs_err(mx1), .max_a(ma1), .max_b(mb1));

  // u2: W=4, LAT=1, two corrupted products
  logic signed [3:0]  a2, b2, ma2, mb2;
  logic signed [7:0]  r2, p2;
  logic               ov2, bz2, dn2;
  logic [8:0]         sc2, ec2, mx2;
  logic [17:0]        sa2;
  logic signed [17:0] bs2;

  function automatic logic signed [7:0] f2(
    input logic signed [3:0] a,
    input logic signed [3:0] b);
    if (a == -4'sd8 && b == -4'sd8) return 8'sd0;
    if (a == 4'sd7 && b == 4'sd7) return 8'sd7;
    return mul4(a, b);
  endfunction

  always_ff @(posedge clk) p2 <= f2(a2, b2);
  assign r2 = p2;

  approx_mul_sweep_monitor #(.W(4), .DUT_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_v[2]),
    .start(start_v[2]), .abort(abort_v[2]),
    .hold(hold_v[2]),
    .op_a(a2), .op_b(b2), .op_valid(ov2),
    .dut_r(r2), .busy(bz2), .done(dn2),
    .sample_cnt(sc2), .err_cnt(ec2),
    .sum_abs_err(sa2), .bias_sum(bs2),
    .max_abs_err(mx2), .max_a(ma2), .max_b(mb2));

  // u3: W=8, LAT=3, ideal
  logic signed [7:0]  a3, b3, ma3, mb3;
  logic signed [15:0] r3, p3a, p3b, p3c;
  logic               ov3, bz3, dn3;
  logic [16:0]        sc3, ec3, mx3;
  logic [33:0]        sa3;
  logic signed [33:0] bs3;

  always_ff @(posedge clk) begin
    p3a <= mul8(a3, b3);
    p3b <= p3a;
    p3c <= p3b;
  end
  assign r3 = p3c;

  approx_mul_sweep_monitor #(.W(8), .DUT_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_v[3]),
    .start(start_v[3]), .abort(abort_v[3]),
    .hold(hold_v[3]),
    .op_a(a3), .op_b(b3), .op_valid(ov3),
    .dut_r(r3), .busy(bz3), .done(dn3),
    .sample_cnt(sc3), .err_cnt(ec3),
    .sum_abs_err(sa3), .bias_sum(bs3),
    .max_abs_err(mx3), .max_a(ma3), .max_b(mb3));

  // Observation mux over the selected instance
  int     sel;
  int     m_a, m_b;
  logic   m_ov, m_done, m_busy;
  longint m_sc, m_ec, m_sa, m_bs;
  longint m_mx, m_ma, m_mb;

  always_comb begin
    m_a = 0; m_b = 0;
    m_ov = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    m_sc = 0; m_ec = 0; m_sa = 0; m_bs = 0;
    m_mx = 0; m_ma = 0; m_mb = 0;
    case (sel)
      0: begin
        m_a = int'(a0); m_b = int'(b0);
        m_ov = ov0; m_done = dn0; m_busy = bz0;
        m_sc = longint'(sc0); m_ec = longint'(ec0);
        m_sa = longint'(sa0); m_bs = longint'(bs0);
        m_mx = longint'(mx0);
        m_ma = longint'(ma0); m_mb = longint'(mb0);
      end
      1: begin
        m_a = int'(a1); m_b = int'(b1);
        m_ov = ov1; m_done = dn1; m_busy = bz1;
        m_sc = longint'(sc1); m_ec = longint'(ec1);
        m_sa = longint'(sa1); m_bs = longint'(bs1);
        m_mx = longint'(mx1);
        m_ma = longint'(ma1); m_mb = longint'(mb1);
      end
      2: begin
        m_a = int'(a2); m_b = int'(b2);
        m_ov = ov2; m_done = dn2; m_busy = bz2;
        m_sc = longint'(sc2); m_ec = longint'(ec2);
        m_sa = longint'(sa2); m_bs = longint'(bs2);
        m_mx = longint'(mx2);
        m_ma = longint'(ma2); m_mb = longint'(mb2);
      end
      3: begin
        m_a = int'(a3); m_b = int'(b3);
        m_ov = ov3; m_done = dn3; m_busy = bz3;
        m_sc = longint'(sc3); m_ec = longint'(ec3);
        m_sa = longint'(sa3); m_bs = longint'(bs3);
        m_mx = longint'(mx3);
        m_ma = longint'(ma3); m_mb = longint'(mb3);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Pulses start, then walks cycles k=0.. (k=0 is the
  // first cycle after the start edge). Tracks issued
  // pairs against the expected order, applies hold in
  // [hold_at, hold_at+hold_len), abort at abort_at, or
  // a reset (with start high) at rst_at.
  task automatic run_sweep(
    input  int hold_at, input int hold_len,
    input  int abort_at, input int rst_at,
    input  int limit,
    output int first, output int done_at,
    output int nv, output int oerr);
    int half, ea, eb;
    half = (sel == 3) ? 128 : 8;
    ea = -half; eb = -half;
    first = -1; done_at = -1; nv = 0; oerr = 0;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    for (int k = 0; k < limit; k++) begin
      hold_v[sel] = (k >= hold_at) &&
                    (k < hold_at + hold_len);
      if (k == abort_at) abort_v[sel] = 1'b1;
      #1;
      if (m_done) begin
        done_at = k;
        break;
      end
      if (hold_v[sel]) begin
        if (m_ov || m_a != ea || m_b != eb)
          oerr++;
      end else if (m_ov) begin
        if (first < 0) first = k;
        nv++;
        if (m_a != ea || m_b != eb) oerr++;
        if (eb == half - 1) begin
          eb = -half;
          ea++;
        end else begin
          eb++;
        end
      end
      if (k == abort_at) begin
        @(negedge clk);
        abort_v[sel] = 1'b0;
        break;
      end
      if (k == rst_at) begin
        rst_v[sel] = 1'b0;
        start_v[sel] = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    hold_v[sel] = 1'b0;
    #1;
  endtask

  int first, dat, nv, oerr;

  initial begin
    rst_v = '0; start_v = '0;
    hold_v = '0; abort_v = '0;
    sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      check("rst_busy", longint'(m_busy), 0);
      check("rst_done", longint'(m_done), 0);
      check("rst_opv", longint'(m_ov), 0);
      check("rst_op_a", m_a, 0);
      check("rst_op_b", m_b, 0);
      check("rst_samples", m_sc, 0);
      check("rst_max", m_mx, 0);
    end
    @(negedge clk);
    rst_v = '1;
    @(negedge clk);

    // ideal model, LAT=2
    sel = 0;
    run_sweep(-1, 0, -1, -1, 400,
              first, dat, nv, oerr);
    check("t1_first", first, 0);
    check("t1_done_lat", dat - first, 258);
    check("t1_nvalid", nv, 256);
    check("t1_order", oerr, 0);
    check("t1_samples", m_sc, 256);
    check("t1_errs", m_ec, 0);
    check("t1_sum", m_sa, 0);
    check("t1_bias", m_bs, 0);
    check("t1_max", m_mx, 0);
    check("t1_max_a", m_ma, 0);
    check("t1_max_b", m_mb, 0);
    repeat (3) @(negedge clk);
    #1;
    check("t1_done_held", longint'(m_done), 1);
    check("t1_frozen", m_sc, 256);

    // hold for 10 cycles mid-run
    run_sweep(100, 10, -1, -1, 400,
              first, dat, nv, oerr);
    check("t4_done_lat", dat - first, 268);
    check("t4_nvalid", nv, 256);
    check("t4_hold_order", oerr, 0);
    check("t4_samples", m_sc, 256);
    check("t4_errs", m_ec, 0);

    // abort on the 100th op_valid cycle
    run_sweep(-1, 0, 99, -1, 400,
              first, dat, nv, oerr);
    check("t5_nvalid", nv, 100);
    check("t5_busy", longint'(m_busy), 0);
    check("t5_done", longint'(m_done), 0);
    check("t5_opv", longint'(m_ov), 0);
    check("t5_samples", m_sc, 98);
    repeat (5) @(negedge clk);
    #1;
    check("t5_frozen", m_sc, 98);
    check("t5_still_idle", longint'(m_busy), 0);
    run_sweep(-1, 0, -1, -1, 400,
              first, dat, nv, oerr);
    check("t5_rerun_lat", dat - first, 258);
    check("t5_rerun_samples", m_sc, 256);

    // exact+1, LAT=0
    sel = 1;
    run_sweep(-1, 0, -1, -1, 400,
              first, dat, nv, oerr);
    check("t2_done_lat", dat - first, 256);
    check("t2_order", oerr, 0);
    check("t2_samples", m_sc, 256);
    check("t2_errs", m_ec, 256);
    check("t2_sum", m_sa, 256);
    check("t2_bias", m_bs, 256);
    check("t2_max", m_mx, 1);
    check("t2_max_a", m_ma, -8);
    check("t2_max_b", m_mb, -8);

    // two corrupted products, LAT=1
    sel = 2;
    run_sweep(-1, 0, -1, -1, 400,
              first, dat, nv, oerr);
    check("t3_done_lat", dat - first, 257);
    check("t3_samples", m_sc, 256);
    check("t3_errs", m_ec, 2);
    check("t3_max", m_mx, 64);
    check("t3_max_a", m_ma, -8);
    check("t3_max_b", m_mb, -8);
    check("t3_sum", m_sa, 106);
    check("t3_bias", m_bs, -106);

    // W=8, reset mid-run with start held high
    sel = 3;
    run_sweep(-1, 0, -1, 50, 400,
              first, dat, nv, oerr);
    check("t6_rst_busy", longint'(m_busy), 0);
    check("t6_rst_done", longint'(m_done), 0);
    check("t6_rst_op_a", m_a, 0);
    check("t6_rst_op_b", m_b, 0);
    check("t6_rst_opv", longint'(m_ov), 0);
    check("t6_rst_samples", m_sc, 0);
    @(negedge clk);
    start_v[3] = 1'b0;
    rst_v[3] = 1'b1;
    #1;
    check("t6_start_ignored", longint'(m_busy), 0);
    @(negedge clk);
    run_sweep(-1, 0, -1, -1, 70000,
              first, dat, nv, oerr);
    check("t6_first", first, 0);
    check("t6_done_lat", dat - first, 65539);
    check("t6_order", oerr, 0);
    check("t6_samples", m_sc, 65536);
    check("t6_errs", m_ec, 0);
    check("t6_max", m_mx, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
